// File: rtl/mux_exerciser.sv
// Stimulus-and-check stage for a 2:1 mux: walks {a, d1, d0} through 0..7,
// holds each vector HOLD_CYCLES cycles, samples i_y on the last hold cycle and scores it.
module mux_exerciser #(
    parameter int HOLD_CYCLES = 10,
    parameter int ERRW        = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_y,
    output logic            o_a,
    output logic            o_d0,
    output logic            o_d1,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [ERRW-1:0] o_err_cnt,
    output logic [2:0]      o_first_fail,
    output logic [2:0]      o_vec
);
    // state | meaning
    // IDLE  | after reset, drives zero, waits for i_start
    // RUN   | stepping vectors and scoring i_y
    // DONE  | results held, i_start restarts a clean pass
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [ERRW-1:0] ERR_MAX   = '1;

    state_t          state, state_next;
    logic            start_run;
    logic [2:0]      vec;
    logic [HW-1:0]   hold;
    logic [ERRW-1:0] err;
    logic [2:0]      first_fail;
    logic            fail_seen;
    logic            last_hold;
    logic            expected;
    logic            mismatch;

    assign last_hold = (hold == HOLD_LAST);
    assign expected  = vec[2] ? vec[1] : vec[0];
    assign mismatch  = (i_y != expected);

    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN: begin
                if (last_hold && (vec == 3'd7)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            vec        <= '0;
            hold       <= '0;
            err        <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            state <= state_next;
            if (start_run) begin
                vec        <= '0;
                hold       <= '0;
                err        <= '0;
                first_fail <= '0;
                fail_seen  <= 1'b0;
            end else if (state == RUN) begin
                if (last_hold) begin
                    hold <= '0;
                    if (mismatch) begin
                        if (err != ERR_MAX) begin
                            err <= err + 1'b1;
                        end
                        if (!fail_seen) begin
                            first_fail <= vec;
                            fail_seen  <= 1'b1;
                        end
                    end
                    // vec parks at 7 in DONE; the drive is gated off below
                    if (vec != 3'd7) begin
                        vec <= vec + 3'd1;
                    end
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end

    assign o_busy       = (state == RUN);
    assign o_done       = (state == DONE);
    assign o_pass       = (state == DONE) && (err == '0);
    assign o_vec        = o_busy ? vec : 3'd0;
    assign o_a          = o_vec[2];
    assign o_d1         = o_vec[1];
    assign o_d0         = o_vec[0];
    assign o_err_cnt    = err;
    assign o_first_fail = first_fail;

endmodule

// File: tb/tb_mux_exerciser.sv
// Directed bench for mux_exerciser: three instances (HOLD 10/ERRW 4, HOLD 10/ERRW 2, HOLD 1/ERRW 4)
// each looped through a behavioural mux that can be correct, stuck at 0 or inverted.
module tb_mux_exerciser;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // mode: 0 correct mux, 1 stuck at 0, 2 inverted
    int mode_m = 0, mode_s = 2, mode_h = 0;
    logic start_m = 1'b0, start_s = 1'b0, start_h = 1'b0;

    logic a_m, d0_m, d1_m, busy_m, done_m, pass_m, y_m;
    logic [3:0] err_m;
    logic [2:0] ff_m, vec_m;
    logic a_s, d0_s, d1_s, busy_s, done_s, pass_s, y_s;
    logic [1:0] err_s;
    logic [2:0] ff_s, vec_s;
    logic a_h, d0_h, d1_h, busy_h, done_h, pass_h, y_h;
    logic [3:0] err_h;
    logic [2:0] ff_h, vec_h;

    function automatic logic mux_y(input int mode, input logic a, input logic d1, input logic d0);
        logic r;
        r = a ? d1 : d0;
        if (mode == 1) return 1'b0;
        if (mode == 2) return ~r;
        return r;
    endfunction

    assign y_m = mux_y(mode_m, a_m, d1_m, d0_m);
    assign y_s = mux_y(mode_s, a_s, d1_s, d0_s);
    assign y_h = mux_y(mode_h, a_h, d1_h, d0_h);

    mux_exerciser #(.HOLD_CYCLES(10), .ERRW(4)) u_main (
        .i_clk(clk), .i_rst(rst), .i_start(start_m), .i_y(y_m),
        .o_a(a_m), .o_d0(d0_m), .o_d1(d1_m), .o_busy(busy_m), .o_done(done_m),
        .o_pass(pass_m), .o_err_cnt(err_m), .o_first_fail(ff_m), .o_vec(vec_m));

    mux_exerciser #(.HOLD_CYCLES(10), .ERRW(2)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_y(y_s),
        .o_a(a_s), .o_d0(d0_s), .o_d1(d1_s), .o_busy(busy_s), .o_done(done_s),
        .o_pass(pass_s), .o_err_cnt(err_s), .o_first_fail(ff_s), .o_vec(vec_s));

    mux_exerciser #(.HOLD_CYCLES(1), .ERRW(4)) u_h1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_h), .i_y(y_h),
        .o_a(a_h), .o_d0(d0_h), .o_d1(d1_h), .o_busy(busy_h), .o_done(done_h),
        .o_pass(pass_h), .o_err_cnt(err_h), .o_first_fail(ff_h), .o_vec(vec_h));

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({a_m, d0_m, d1_m, busy_m, done_m, pass_m, err_m, ff_m, vec_m} !== '0) begin
            fails++;
            $display("FAIL reset_main got busy=%b done=%b pass=%b err=%0d ff=%0d vec=%0d want all 0",
                     busy_m, done_m, pass_m, err_m, ff_m, vec_m);
        end
        tests++;
        if ({a_s, d0_s, d1_s, busy_s, done_s, pass_s, err_s, ff_s, vec_s} !== '0) begin
            fails++;
            $display("FAIL reset_sat got busy=%b done=%b err=%0d vec=%0d want all 0", busy_s, done_s, err_s, vec_s);
        end
        tests++;
        if ({a_h, d0_h, d1_h, busy_h, done_h, pass_h, err_h, ff_h, vec_h} !== '0) begin
            fails++;
            $display("FAIL reset_h1 got busy=%b done=%b err=%0d vec=%0d want all 0", busy_h, done_h, err_h, vec_h);
        end
    endtask

    // Full pass on u_main: start accepted at the next edge, 80 cycles of vectors, then DONE.
    task automatic run_main(input int mode, input bit keep_start, input int want_err,
                            input int want_ff, input bit want_pass);
        int   m_err = 0;
        int   m_ff  = 0;
        bit   m_seen = 0;
        logic [2:0] v;
        mode_m  = mode;
        start_m = 1'b1;
        @(negedge clk);
        if (!keep_start) start_m = 1'b0;
        for (int c = 0; c < 80; c++) begin
            v = 3'(c / 10);
            if (c > 0 && c % 10 == 0) begin
                logic [2:0] pv;
                pv = 3'(c / 10 - 1);
                if (mux_y(mode, pv[2], pv[1], pv[0]) !== mux_y(0, pv[2], pv[1], pv[0])) begin
                    m_err++;
                    if (!m_seen) begin m_ff = int'(pv); m_seen = 1; end
                end
            end
            tests++;
            if (busy_m !== 1'b1 || done_m !== 1'b0 || vec_m !== v || {a_m, d1_m, d0_m} !== v) begin
                fails++;
                $display("FAIL run_vec c=%0d got busy=%b done=%b vec=%0d adrive=%b%b%b want busy=1 vec=%0d",
                         c, busy_m, done_m, vec_m, a_m, d1_m, d0_m, v);
            end
            tests++;
            if (err_m !== 4'(m_err) || ff_m !== 3'(m_ff)) begin
                fails++;
                $display("FAIL run_err c=%0d got err=%0d ff=%0d want err=%0d ff=%0d", c, err_m, ff_m, m_err, m_ff);
            end
            @(negedge clk);
        end
        tests++;
        if (done_m !== 1'b1 || busy_m !== 1'b0 || vec_m !== 3'd0 || {a_m, d1_m, d0_m} !== 3'b000) begin
            fails++;
            $display("FAIL done_state got done=%b busy=%b vec=%0d want done=1 busy=0 vec=0", done_m, busy_m, vec_m);
        end
        tests++;
        if (err_m !== 4'(want_err) || ff_m !== 3'(want_ff) || pass_m !== want_pass) begin
            fails++;
            $display("FAIL done_result mode=%0d got err=%0d ff=%0d pass=%b want err=%0d ff=%0d pass=%b",
                     mode, err_m, ff_m, pass_m, want_err, want_ff, want_pass);
        end
    endtask

    task automatic test_patterns();
        run_main(0, 0, 0, 0, 1);
        run_main(1, 0, 4, 1, 0);
        run_main(2, 0, 8, 0, 0);
        repeat (5) @(negedge clk);
        tests++;
        if (done_m !== 1'b1 || err_m !== 4'd8) begin
            fails++;
            $display("FAIL done_hold got done=%b err=%0d want done=1 err=8", done_m, err_m);
        end
    endtask

    task automatic test_reset_mid_run();
        mode_m  = 1;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (35) @(negedge clk);
        tests++;
        if (busy_m !== 1'b1 || vec_m !== 3'd3 || err_m !== 4'd1 || ff_m !== 3'd1) begin
            fails++;
            $display("FAIL mid_run got busy=%b vec=%0d err=%0d ff=%0d want busy=1 vec=3 err=1 ff=1",
                     busy_m, vec_m, err_m, ff_m);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({a_m, d0_m, d1_m, busy_m, done_m, pass_m, err_m, ff_m, vec_m} !== '0) begin
            fails++;
            $display("FAIL reset_mid got busy=%b done=%b err=%0d ff=%0d vec=%0d want all 0",
                     busy_m, done_m, err_m, ff_m, vec_m);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (busy_m !== 1'b0 || done_m !== 1'b0) begin
            fails++;
            $display("FAIL idle_wait got busy=%b done=%b want 0 0", busy_m, done_m);
        end
        run_main(0, 0, 0, 0, 1);
    endtask

    task automatic test_start_held();
        run_main(2, 1, 8, 0, 0);
        // start still high in DONE: the following edge restarts and clears the count
        run_main(0, 0, 0, 0, 1);
    endtask

    task automatic test_saturate();
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (30) @(negedge clk);
        tests++;
        if (err_s !== 2'd3 || busy_s !== 1'b1) begin
            fails++;
            $display("FAIL sat_mid got err=%0d busy=%b want err=3 busy=1", err_s, busy_s);
        end
        repeat (50) @(negedge clk);
        tests++;
        if (done_s !== 1'b1 || err_s !== 2'd3 || pass_s !== 1'b0 || ff_s !== 3'd0) begin
            fails++;
            $display("FAIL sat_done got done=%b err=%0d pass=%b ff=%0d want done=1 err=3 pass=0 ff=0",
                     done_s, err_s, pass_s, ff_s);
        end
    endtask

    task automatic test_hold_one(input int mode, input int want_err, input int want_ff, input bit want_pass);
        mode_h  = mode;
        start_h = 1'b1;
        @(negedge clk);
        start_h = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tests++;
            if (busy_h !== 1'b1 || vec_h !== 3'(c)) begin
                fails++;
                $display("FAIL h1_vec c=%0d got busy=%b vec=%0d want busy=1 vec=%0d", c, busy_h, vec_h, c);
            end
            @(negedge clk);
        end
        tests++;
        if (done_h !== 1'b1 || busy_h !== 1'b0 || err_h !== 4'(want_err) || ff_h !== 3'(want_ff)
            || pass_h !== want_pass) begin
            fails++;
            $display("FAIL h1_done got done=%b busy=%b err=%0d ff=%0d pass=%b want done=1 err=%0d ff=%0d pass=%b",
                     done_h, busy_h, err_h, ff_h, pass_h, want_err, want_ff, want_pass);
        end
    endtask

    initial begin
        test_reset();
        repeat (2) @(negedge clk);
        test_patterns();
        test_reset_mid_run();
        test_start_held();
        start_m = 1'b0;
        test_saturate();
        test_hold_one(0, 0, 0, 1);
        test_hold_one(1, 4, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
